// File: rtl/adder_32_pkg.sv
`default_nettype none
// ============================================================================
// Package     : adder_32_pkg
// Description : Shared constants and state encoding for the shared-adder
//               arbiter (operand width, op counter width, FSM states).
// Revision    : 1.0 - initial release
// ============================================================================
package adder_32_pkg;

    localparam int ADD_WIDTH = 32;
    localparam int OP_CNT_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage : adder_32_pkg
`default_nettype wire

// File: rtl/adder_32_share_arb_rr.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter_n
// Description : Round-robin arbiter. Picks the first asserted request at or
//               after the pointer (circular) and advances the pointer past
//               the winner when the grant is actually consumed.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter_n #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               advance_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    idx_o,
    output logic               any_o
);

    logic [ID_W-1:0]    ptr_q;
    logic [ID_W-1:0]    ptr_d;
    logic [NUM_REQ-1:0] w_masked;
    logic [ID_W-1:0]    w_hi_idx;
    logic [ID_W-1:0]    w_lo_idx;

    // Lowest request at/above the pointer wins; otherwise wrap to the lowest request overall.
    always_comb begin
        w_masked = '0;
        w_hi_idx = '0;
        w_lo_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_masked[i] = req_i[i] && (ID_W'(i) >= ptr_q);
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_masked[i]) w_hi_idx = ID_W'(i);
            if (req_i[i])    w_lo_idx = ID_W'(i);
        end
    end

    assign any_o = |req_i;
    assign idx_o = (|w_masked) ? w_hi_idx : w_lo_idx;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant
            assign grant_o[gi] = any_o && (idx_o == ID_W'(gi));
        end
    endgenerate

    assign ptr_d = (idx_o == ID_W'(NUM_REQ - 1)) ? '0 : idx_o + 1'b1;

    // Pointer moves only when the grant is consumed, so an unserved winner keeps priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (advance_i) begin
            ptr_q <= ptr_d;
        end
    end

endmodule : rr_arbiter_n
`default_nettype wire

// File: rtl/adder_32_share_arb.sv
`default_nettype none
// ============================================================================
// Module      : adder_32_share_arb
// Description : Time-shares one external combinational adder among NUM_REQ
//               requesters. Round-robin grant, registered operand drive,
//               registered tagged result with valid/ready, op counter.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_32_share_arb
    import adder_32_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int WIDTH   = ADD_WIDTH,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    input  logic [NUM_REQ*WIDTH-1:0] req_a_i,
    input  logic [NUM_REQ*WIDTH-1:0] req_b_i,
    input  logic [NUM_REQ-1:0]       req_cin_i,
    output logic [WIDTH-1:0]         add_in1_o,
    output logic [WIDTH-1:0]         add_in2_o,
    output logic                     add_cin_o,
    input  logic [WIDTH-1:0]         add_sum_i,
    input  logic                     add_cout_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [WIDTH-1:0]         rsp_sum_o,
    output logic                     rsp_cout_o,
    output logic [ID_W-1:0]          rsp_id_o,
    output logic [OP_CNT_W-1:0]      op_count_o
);

    state_e               state_q;
    logic [WIDTH-1:0]     add_in1_q;
    logic [WIDTH-1:0]     add_in2_q;
    logic                 add_cin_q;
    logic [ID_W-1:0]      tag_q;
    logic                 rsp_valid_q;
    logic [WIDTH-1:0]     rsp_sum_q;
    logic                 rsp_cout_q;
    logic [ID_W-1:0]      rsp_id_q;
    logic [OP_CNT_W-1:0]  op_count_q;

    logic [WIDTH-1:0]     w_a [NUM_REQ];
    logic [WIDTH-1:0]     w_b [NUM_REQ];
    logic [NUM_REQ-1:0]   w_grant;
    logic [ID_W-1:0]      w_idx;
    logic                 w_any;
    logic                 w_grant_en;
    logic                 w_accept;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_a[gi] = req_a_i[gi*WIDTH +: WIDTH];
            assign w_b[gi] = req_b_i[gi*WIDTH +: WIDTH];
        end
    endgenerate

    rr_arbiter_n #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (req_valid_i),
        .advance_i (w_accept),
        .grant_o   (w_grant),
        .idx_o     (w_idx),
        .any_o     (w_any)
    );

    // A new op may start only when the adder slot is free or is being freed this cycle.
    assign w_grant_en  = (state_q == ST_IDLE) || ((state_q == ST_RESP) && rsp_ready_i);
    assign req_ready_o = w_grant_en ? w_grant : '0;
    assign w_accept    = w_grant_en && w_any;

    // Controller: launch operands, capture the adder result, hold it until consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            add_in1_q   <= '0;
            add_in2_q   <= '0;
            add_cin_q   <= 1'b0;
            tag_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
            rsp_id_q    <= '0;
            op_count_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_accept) begin
                        add_in1_q <= w_a[w_idx];
                        add_in2_q <= w_b[w_idx];
                        add_cin_q <= req_cin_i[w_idx];
                        tag_q     <= w_idx;
                        state_q   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_sum_q   <= add_sum_i;
                    rsp_cout_q  <= add_cout_i;
                    rsp_id_q    <= tag_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        op_count_q  <= op_count_q + 1'b1;
                        if (w_accept) begin
                            add_in1_q <= w_a[w_idx];
                            add_in2_q <= w_b[w_idx];
                            add_cin_q <= req_cin_i[w_idx];
                            tag_q     <= w_idx;
                            state_q   <= ST_EXEC;
                        end else begin
                            state_q   <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign add_in1_o   = add_in1_q;
    assign add_in2_o   = add_in2_q;
    assign add_cin_o   = add_cin_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_sum_o   = rsp_sum_q;
    assign rsp_cout_o  = rsp_cout_q;
    assign rsp_id_o    = rsp_id_q;
    assign op_count_o  = op_count_q;

endmodule : adder_32_share_arb
`default_nettype wire

// File: tb/tb_adder_32_share_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder_32_share_arb
// Description : Scoreboard bench for the shared-adder arbiter. A grant
//               tracker predicts round-robin grants and pushes expected
//               results; a response monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_32_share_arb;

    localparam int N = 4;
    localparam int W = 32;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        int           id;
        int           acc_cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     req_valid = '0;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [N-1:0]     req_cin = '0;
    logic [W-1:0]     add_in1, add_in2, add_sum;
    logic             add_cin, add_cout;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [W-1:0]     rsp_sum;
    logic             rsp_cout;
    logic [1:0]       rsp_id;
    logic [15:0]      op_count;

    logic [W-1:0]     a_arr [N];
    logic [W-1:0]     b_arr [N];

    int               checks = 0;
    int               errors = 0;
    int               cyc = 0;

    exp_t             sb[$];
    bit               busy = 1'b0;
    int               ptr = 0;
    logic [15:0]      mcnt = '0;
    bit               prev_v = 1'b0;
    int               rise = 0;

    adder_32_share_arb #(
        .NUM_REQ (N),
        .WIDTH   (W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_a_i     (req_a),
        .req_b_i     (req_b),
        .req_cin_i   (req_cin),
        .add_in1_o   (add_in1),
        .add_in2_o   (add_in2),
        .add_cin_o   (add_cin),
        .add_sum_i   (add_sum),
        .add_cout_i  (add_cout),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_sum_o   (rsp_sum),
        .rsp_cout_o  (rsp_cout),
        .rsp_id_o    (rsp_id),
        .op_count_o  (op_count)
    );

    // The shared combinational adder that normally lives one level up.
    assign {add_cout, add_sum} = {1'b0, add_in1} + {1'b0, add_in2} + {32'b0, add_cin};

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = a_arr[i];
            req_b[i*W +: W] = b_arr[i];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Grant tracker: one op outstanding at a time, round-robin from the model pointer.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy = 1'b0;
            ptr  = 0;
            sb.delete();
        end else begin
            bit           allowed;
            int           g;
            logic [1:0]   j;
            logic [N-1:0] exp_rdy;
            logic [W:0]   tot;
            exp_t         e;
            allowed = !busy || (rsp_valid && rsp_ready);
            g = 0;
            exp_rdy = '0;
            if (allowed && (req_valid != '0)) begin
                for (int k = N - 1; k >= 0; k--) begin
                    j = 2'(ptr + k);
                    if (req_valid[j]) g = int'(j);
                end
                exp_rdy[g] = 1'b1;
            end
            chk("req_ready", 64'(req_ready), 64'(exp_rdy));
            if (exp_rdy != '0) begin
                tot = {1'b0, a_arr[g]} + {1'b0, b_arr[g]} + 33'(req_cin[g]);
                e.sum = tot[W-1:0];
                e.cout = tot[W];
                e.id = g;
                e.acc_cyc = cyc;
                sb.push_back(e);
                ptr = (g + 1) % N;
                busy = 1'b1;
            end else if (rsp_valid && rsp_ready) begin
                busy = 1'b0;
            end
        end
    end

    // Response monitor: compare presented results with the scoreboard head.
    always @(negedge clk) begin
        if (!rst_n) begin
            mcnt   = '0;
            prev_v = 1'b0;
        end else begin
            chk("op_count", 64'(op_count), 64'(mcnt));
            if (rsp_valid) begin
                if (!prev_v) rise = cyc;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got rsp_valid=1 id=%0d expected no response (cycle %0d)", rsp_id, cyc);
                end else begin
                    chk("rsp_sum", 64'(rsp_sum), 64'(sb[0].sum));
                    chk("rsp_cout", 64'(rsp_cout), 64'(sb[0].cout));
                    chk("rsp_id", 64'(rsp_id), 64'(sb[0].id));
                    if (!prev_v) chk("latency", 64'(rise - sb[0].acc_cyc), 64'd2);
                    if (rsp_ready) begin
                        void'(sb.pop_front());
                        mcnt = mcnt + 16'd1;
                    end
                end
            end
            prev_v = rsp_valid && !rsp_ready;
        end
    end

    task automatic new_ops(input int i);
        a_arr[i] = $urandom;
        b_arr[i] = $urandom;
        req_cin[i] = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 7))
            0: a_arr[i] = 32'hFFFF_FFFF;
            1: begin a_arr[i] = 32'hFFFF_FFFF; b_arr[i] = 32'h0; req_cin[i] = 1'b1; end
            2: begin a_arr[i] = 32'h0; b_arr[i] = 32'h0; end
            default: ;
        endcase
    endtask

    // One cycle; accepted requesters either reload (keep) or drop their request.
    task automatic step(input logic [N-1:0] keep, output logic [N-1:0] acc);
        @(negedge clk);
        acc = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                if (keep[i]) new_ops(i);
                else         req_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic issue(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        logic [N-1:0] acc;
        bit           done;
        a_arr[i] = a;
        b_arr[i] = b;
        req_cin[i] = c;
        req_valid[i] = 1'b1;
        done = 1'b0;
        for (int t = 0; t < 40 && !done; t++) begin
            step('0, acc);
            if (acc[i]) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: got no grant for req%0d expected grant within 40 cycles", i);
            req_valid[i] = 1'b0;
        end
    endtask

    task automatic wait_rsp(output logic [W-1:0] s, output logic c, output logic [1:0] id, output int n);
        n = 0; s = '0; c = 1'b0; id = '0;
        for (int t = 1; t <= 20; t++) begin
            @(negedge clk);
            if (rsp_valid) begin
                n = t; s = rsp_sum; c = rsp_cout; id = rsp_id;
                break;
            end
        end
        if (n == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout: got no rsp_valid expected one within 20 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        logic [N-1:0] acc;
        for (int t = 0; t < 80 && (req_valid != '0 || rsp_valid || busy); t++) step('0, acc);
        repeat (2) step('0, acc);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1);
    end

    initial begin
        logic [N-1:0] acc;
        logic [W-1:0] s;
        logic         c;
        logic [1:0]   id;
        int           n;
        int           gidx [5];
        int           gcyc [5];
        int           exp_ids [5] = '{0, 1, 2, 3, 0};
        int           gcount, pos;

        for (int i = 0; i < N; i++) begin a_arr[i] = '0; b_arr[i] = '0; end

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_add_in1", 64'(add_in1), 64'd0);
        chk("rst_add_in2", 64'(add_in2), 64'd0);
        chk("rst_add_cin", 64'(add_cin), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_sum", 64'(rsp_sum), 64'd0);
        chk("rst_rsp_cout", 64'(rsp_cout), 64'd0);
        chk("rst_rsp_id", 64'(rsp_id), 64'd0);
        chk("rst_op_count", 64'(op_count), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // All four requesters continuously valid: ids 0,1,2,3,0 one every 2 cycles
        rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) new_ops(i);
        req_valid = '1;
        n = 0;
        for (int t = 0; t < 40 && n < 5; t++) begin
            step('1, acc);
            if (acc != '0) begin
                for (int i = 0; i < N; i++) if (acc[i]) gidx[n] = i;
                gcyc[n] = cyc;
                n++;
            end
        end
        chk("rr_grant_count", 64'(n), 64'd5);
        for (int k = 0; k < 5; k++) chk($sformatf("rr_order_%0d", k), 64'(gidx[k]), 64'(exp_ids[k]));
        for (int k = 1; k < 5; k++) chk($sformatf("rr_gap_%0d", k), 64'(gcyc[k] - gcyc[k-1]), 64'd2);
        req_valid = '0;
        drain();

        // Single request: 5 + 7 + 1
        issue(0, 32'd5, 32'd7, 1'b1);
        wait_rsp(s, c, id, n);
        chk("single_sum", 64'(s), 64'd13);
        chk("single_cout", 64'(c), 64'd0);
        chk("single_id", 64'(id), 64'd0);
        chk("single_latency", 64'(n), 64'd2);

        // Carry wrap
        issue(2, 32'hFFFF_FFFF, 32'h0, 1'b1);
        wait_rsp(s, c, id, n);
        chk("wrap_sum", 64'(s), 64'd0);
        chk("wrap_cout", 64'(c), 64'd1);
        chk("wrap_id", 64'(id), 64'd2);
        drain();

        // Backpressure: response held, no grants, counter frozen
        rsp_ready = 1'b0;
        issue(1, 32'h1234_5678, 32'h1111_1111, 1'b0);
        new_ops(0); new_ops(3);
        req_valid[0] = 1'b1;
        req_valid[3] = 1'b1;
        @(negedge clk);
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            chk("bp_req_ready", 64'(req_ready), 64'd0);
            chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
            chk("bp_rsp_sum", 64'(rsp_sum), 64'h2345_6789);
            chk("bp_rsp_id", 64'(rsp_id), 64'd1);
            chk("bp_op_count", 64'(op_count), 64'd7);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        drain();

        // Fairness: req1 permanently requesting, req3 raised later
        new_ops(1);
        req_valid[1] = 1'b1;
        repeat (4) step(4'b0010, acc);
        new_ops(3);
        req_valid[3] = 1'b1;
        gcount = 0;
        pos = 0;
        for (int t = 0; t < 20 && pos == 0; t++) begin
            step(4'b0010, acc);
            if (acc != '0) begin
                gcount++;
                if (acc[3]) pos = gcount;
            end
        end
        chk("fair_req3_within_2", 64'((pos >= 1) && (pos <= 2)), 64'd1);
        req_valid[1] = 1'b0;
        drain();

        // Randomized traffic with random backpressure and abandoned requests
        for (int t = 0; t < 400; t++) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    new_ops(i);
                    req_valid[i] = 1'b1;
                end else if (req_valid[i] && $urandom_range(0, 15) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            step(4'($urandom), acc);
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        drain();
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        // Asynchronous reset while an op is in EXEC
        issue(0, 32'hDEAD_BEEF, 32'h0000_0001, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("arst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("arst_req_ready", 64'(req_ready), 64'd0);
        chk("arst_add_in1", 64'(add_in1), 64'd0);
        chk("arst_add_cin", 64'(add_cin), 64'd0);
        chk("arst_rsp_sum", 64'(rsp_sum), 64'd0);
        chk("arst_op_count", 64'(op_count), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            chk("post_rst_no_rsp", 64'(rsp_valid), 64'd0);
        end
        chk("post_rst_op_count", 64'(op_count), 64'd0);
        @(posedge clk);
        #1;

        // Pointer restarts at requester 0
        for (int i = 0; i < N; i++) new_ops(i);
        req_valid = '1;
        step('0, acc);
        chk("post_rst_first_grant", 64'(acc), 64'd1);
        drain();
        chk("final_scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_adder_32_share_arb
`default_nettype wire
